pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipes.sv | 21 ++
 rtl/pipe_ring_ptr.sv | 30 +++
 rtl/pipe_skid_reg.sv | 119 +++++++++++
 tb/tb_pipe_skid_reg.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipes.sv
// Shared pipe-stage package: skid-stage default parameters, per-stage
// payload typedefs and a pointer-width helper used by the skid stage.
// Wrappers pass $bits(<payload_t>) as the WIDTH of a pipe_skid_reg.
package pipes;

    localparam int unsigned SKID_WIDTH_DEF    = 64;
    localparam int unsigned SKID_DEPTH_DEF    = 2;
    localparam bit          SKID_CLR_ZERO_DEF = 1'b1;

    // Decode-stage payload carried through a skid stage.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } decode_data_t;

    // Pointer width for a ring of 'depth' entries; never below one bit.
    function automatic int unsigned ptrWidth(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_ring_ptr.sv
// Modulo-DEPTH ring pointer with increment enable and synchronous clear.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, pointer to 0
//   clr  - synchronous clear, pointer to 0
//   inc  - advance pointer by one, wrapping DEPTH-1 -> 0
//   ptr  - current pointer value
module pipe_ring_ptr
    import pipes::*;
#(
    parameter int unsigned DEPTH = SKID_DEPTH_DEF,
    parameter int unsigned PW    = ptrWidth(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    // Clear has priority over increment.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Parameterised skid/FIFO pipeline stage with registered handshake outputs.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   flush               - synchronous discard of all held entries
//   in_valid/in_ready   - upstream handshake, in_data payload
//   out_valid/out_ready - downstream handshake, out_data head payload
//   occupancy           - number of held entries
module pipe_skid_reg
    import pipes::*;
#(
    parameter int unsigned WIDTH    = SKID_WIDTH_DEF,
    parameter int unsigned DEPTH    = SKID_DEPTH_DEF,
    parameter bit          CLR_ZERO = SKID_CLR_ZERO_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned PW = ptrWidth(DEPTH);
    localparam int unsigned OW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    rdInc;
    logic [OW-1:0]    occ;
    logic [OW-1:0]    occNext;
    logic             inReadyQ;
    logic             outValidQ;
    logic [WIDTH-1:0] outDataQ;
    logic [WIDTH-1:0] headNext;
    logic             doPush;
    logic             doPop;

    // Handshake qualification, next occupancy and next head payload.
    always_comb begin
        doPush  = in_valid && inReadyQ && !rst && !flush;
        doPop   = outValidQ && out_ready && !rst && !flush;
        rdInc   = (rdPtr == PW'(DEPTH - 1)) ? '0 : rdPtr + PW'(1);
        occNext = occ;
        if (doPush && !doPop) begin
            occNext = occ + OW'(1);
        end else if (doPop && !doPush) begin
            occNext = occ - OW'(1);
        end
        // The head register is preloaded: an incoming word becomes the head
        // directly when the stage is (or is about to be) otherwise empty.
        headNext = outDataQ;
        if (occNext == '0) begin
            headNext = '0;
        end else if (doPop) begin
            headNext = (occ == OW'(1)) ? in_data : mem[rdInc];
        end else if (occ == '0) begin
            headNext = in_data;
        end
    end

    pipe_ring_ptr #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) wrPtrInst (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (doPush),
        .ptr (wrPtr)
    );

    pipe_ring_ptr #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) rdPtrInst (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (doPop),
        .ptr (rdPtr)
    );

    // Occupancy and registered output flags/payload.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ       <= '0;
            inReadyQ  <= 1'b1;
            outValidQ <= 1'b0;
            outDataQ  <= '0;
        end else begin
            occ       <= occNext;
            inReadyQ  <= (occNext != OW'(DEPTH));
            outValidQ <= (occNext != '0);
            outDataQ  <= headNext;
        end
    end

    // Entry storage; only accepted pushes write.
    always_ff @(posedge clk) begin
        if ((rst || flush) && CLR_ZERO) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                mem[e] <= '0;
            end
        end else if (doPush) begin
            mem[wrPtr] <= in_data;
        end
    end

    assign in_ready  = inReadyQ;
    assign out_valid = outValidQ;
    assign out_data  = outDataQ;
    assign occupancy = occ;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: three instances (DEPTH 1, 2, 3) checked every
// cycle against a count-based queue model, plus directed scenarios.
module tb_pipe_skid_reg;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         flush    [3];
    logic         inValid  [3];
    logic         outReady [3];
    logic [W-1:0] inData   [3];

    wire  [2:0]        inReady;
    wire  [2:0]        outValid;
    wire  [2:0][W-1:0] outData;
    wire  [0:0]        occD1;
    wire  [1:0]        occD2;
    wire  [1:0]        occD3;

    int testsRun    = 0;
    int testsFailed = 0;
    bit chkOn       = 1'b0;

    pipe_skid_reg #(.WIDTH(W), .DEPTH(1), .CLR_ZERO(1'b1)) dutD1 (
        .clk(clk), .rst(rst), .flush(flush[0]),
        .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0]),
        .out_valid(outValid[0]), .out_ready(outReady[0]), .out_data(outData[0]),
        .occupancy(occD1)
    );

    pipe_skid_reg #(.WIDTH(W), .DEPTH(2), .CLR_ZERO(1'b1)) dutD2 (
        .clk(clk), .rst(rst), .flush(flush[1]),
        .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]),
        .out_valid(outValid[1]), .out_ready(outReady[1]), .out_data(outData[1]),
        .occupancy(occD2)
    );

    pipe_skid_reg #(.WIDTH(W), .DEPTH(3), .CLR_ZERO(1'b0)) dutD3 (
        .clk(clk), .rst(rst), .flush(flush[2]),
        .in_valid(inValid[2]), .in_ready(inReady[2]), .in_data(inData[2]),
        .out_valid(outValid[2]), .out_ready(outReady[2]), .out_data(outData[2]),
        .occupancy(occD3)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned depthOf(input int i);
        return 32'(i + 1);
    endfunction

    function automatic logic [31:0] occOf(input int i);
        case (i)
            0:       return 32'(occD1);
            1:       return 32'(occD2);
            default: return 32'(occD3);
        endcase
    endfunction

    // Model: total pushed / popped counters (mod 256) over a large buffer.
    logic [W-1:0] mBuf [3][256];
    logic [7:0]   mWr  [3];
    logic [7:0]   mRd  [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            automatic int unsigned cnt = 32'(8'(mWr[i] - mRd[i]));
            if (rst || flush[i]) begin
                mRd[i] <= mWr[i];
            end else begin
                if (cnt != 0 && outReady[i]) mRd[i] <= mRd[i] + 8'd1;
                if (inValid[i] && cnt < depthOf(i)) begin
                    mBuf[i][mWr[i]] <= inData[i];
                    mWr[i]          <= mWr[i] + 8'd1;
                end
            end
        end
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (chkOn) begin
            for (int i = 0; i < 3; i++) begin
                automatic int unsigned cnt = 32'(8'(mWr[i] - mRd[i]));
                automatic logic [W-1:0] head = (cnt != 0) ? mBuf[i][mRd[i]] : '0;
                checkVal($sformatf("d%0d.occupancy", i + 1), occOf(i), 32'(cnt));
                checkVal($sformatf("d%0d.in_ready", i + 1), 32'(inReady[i]), 32'(cnt < depthOf(i)));
                checkVal($sformatf("d%0d.out_valid", i + 1), 32'(outValid[i]), 32'(cnt != 0));
                checkVal($sformatf("d%0d.out_data", i + 1), 32'(outData[i]), 32'(head));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleAll();
        for (int i = 0; i < 3; i++) begin
            flush[i]    = 1'b0;
            inValid[i]  = 1'b0;
            outReady[i] = 1'b0;
            inData[i]   = '0;
        end
    endtask

    task automatic checkD2(input string tag, input int o, input bit ir, input bit ov, input logic [W-1:0] d);
        checkVal({tag, ".occ"}, occOf(1), 32'(o));
        checkVal({tag, ".in_ready"}, 32'(inReady[1]), 32'(ir));
        checkVal({tag, ".out_valid"}, 32'(outValid[1]), 32'(ov));
        checkVal({tag, ".out_data"}, 32'(outData[1]), 32'(d));
    endtask

    // Stream 100 items through instance i with an always-ready source/sink.
    task automatic streamRun(input int i, input int expSpan);
        int pushed = 0;
        int popped = 0;
        int first  = -1;
        int last   = -1;
        flush[i] = 1'b1;
        tick();
        flush[i]    = 1'b0;
        outReady[i] = 1'b1;
        for (int cyc = 0; cyc < 1000 && popped < 100; cyc++) begin
            automatic bit willPush;
            automatic bit willPop;
            inValid[i] = (pushed < 100);
            inData[i]  = W'(pushed + 16'h100);
            willPush   = inValid[i] && inReady[i];
            willPop    = outValid[i] && outReady[i];
            tick();
            if (willPush) begin
                pushed++;
                if (first < 0) first = cyc;
            end
            if (willPop) begin
                popped++;
                last = cyc;
            end
        end
        idleAll();
        checkVal($sformatf("tput.d%0d.transfers", i + 1), 32'(popped), 32'd100);
        checkVal($sformatf("tput.d%0d.span", i + 1), 32'(last - first), 32'(expSpan));
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            mWr[i] = '0;
            mRd[i] = '0;
        end
        rst = 1'b1;
        idleAll();
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        chkOn = 1'b1;

        // Reset state.
        for (int i = 0; i < 3; i++) begin
            checkVal($sformatf("rst.d%0d.occ", i + 1), occOf(i), 32'd0);
            checkVal($sformatf("rst.d%0d.in_ready", i + 1), 32'(inReady[i]), 32'd1);
            checkVal($sformatf("rst.d%0d.out_valid", i + 1), 32'(outValid[i]), 32'd0);
            checkVal($sformatf("rst.d%0d.out_data", i + 1), 32'(outData[i]), 32'd0);
        end

        // Fill DEPTH=2, refuse a third push.
        inValid[1] = 1'b1; inData[1] = 16'h000A; tick();
        checkD2("lat1", 1, 1'b1, 1'b1, 16'h000A);
        inData[1] = 16'h000B; tick();
        checkD2("full", 2, 1'b0, 1'b1, 16'h000A);
        inData[1] = 16'h000C; tick();
        checkD2("refuse", 2, 1'b0, 1'b1, 16'h000A);

        // Pop while full: 0xC refused that cycle, accepted the next.
        outReady[1] = 1'b1; tick();
        checkD2("popfull", 1, 1'b1, 1'b1, 16'h000B);
        tick();
        checkD2("pushpop", 1, 1'b1, 1'b1, 16'h000C);
        inValid[1] = 1'b0; tick();
        checkD2("drain", 0, 1'b1, 1'b0, 16'h0000);
        tick();
        checkD2("emptyrdy", 0, 1'b1, 1'b0, 16'h0000);

        // Flush with two held entries and a push offered.
        outReady[1] = 1'b0; inValid[1] = 1'b1;
        inData[1] = 16'h0011; tick();
        inData[1] = 16'h0022; tick();
        flush[1] = 1'b1; outReady[1] = 1'b1; inData[1] = 16'h0033; tick();
        flush[1] = 1'b0; inValid[1] = 1'b0;
        checkD2("flush", 0, 1'b1, 1'b0, 16'h0000);
        tick();
        checkD2("flushlost", 0, 1'b1, 1'b0, 16'h0000);
        idleAll();

        // Randomised traffic on all instances, occasional flushes.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 3; i++) begin
                inValid[i]  = ($urandom_range(0, 99) < 60);
                outReady[i] = ($urandom_range(0, 99) < 50);
                flush[i]    = ($urandom_range(0, 99) < 3);
                inData[i]   = W'($urandom);
            end
            tick();
        end

        // Mid-stream reset together with flush.
        for (int i = 0; i < 3; i++) begin
            flush[i] = 1'b0; outReady[i] = 1'b0; inValid[i] = 1'b1;
            inData[i] = W'(16'h0700 + i);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) flush[i] = 1'b1;
        tick();
        rst = 1'b0;
        idleAll();
        for (int i = 0; i < 3; i++) begin
            checkVal($sformatf("rstmid.d%0d.occ", i + 1), occOf(i), 32'd0);
            checkVal($sformatf("rstmid.d%0d.in_ready", i + 1), 32'(inReady[i]), 32'd1);
            checkVal($sformatf("rstmid.d%0d.out_valid", i + 1), 32'(outValid[i]), 32'd0);
            checkVal($sformatf("rstmid.d%0d.out_data", i + 1), 32'(outData[i]), 32'd0);
        end
        inValid[1] = 1'b1; inData[1] = 16'h0055; tick();
        inValid[1] = 1'b0;
        checkD2("rstpush", 1, 1'b1, 1'b1, 16'h0055);
        outReady[1] = 1'b1; tick();
        idleAll();

        // Sustained throughput.
        streamRun(1, 100);
        streamRun(2, 100);
        streamRun(0, 199);

        tick();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", testsRun);
        $fatal(1, "time limit");
    end

endmodule
